// File: rtl/mem_access.sv
// Memory-access stage: issues byte/half/word loads and stores on a req/ack port,
// stalls upstream while a transaction is outstanding, and produces the register writeback.
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [11:0] code,
  input  logic [4:0]  rdAddress,
  input  logic [31:0] dataOut_r,
  input  logic [31:0] dataOut_m,
  input  logic [31:0] memAddress,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic          mem_req_d, mem_we_d, wb_en_d, err_d;
  logic [31:0]   mem_addr_d, mem_wdata_d, wb_data_d;
  logic [3:0]    mem_be_d;
  logic [4:0]    wb_addr_d;
  logic          stall_c;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, f3_ok, misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, shifted_c, ld_data_c;
  logic        unused_bits;

  assign opcode      = code[6:0];
  assign funct3      = code[9:7];
  assign unused_bits = ^code[11:10];
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign stall       = stall_c;

  // Decode legality, alignment and store lane placement
  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = dataOut_m;
    if (is_load)
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    else if (is_store)
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    case (funct3[1:0])
      2'b01:   misaligned = memAddress[0];
      2'b10:   misaligned = (memAddress[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << memAddress[1:0]);
        wdata_c = {4{dataOut_m[7:0]}};
      end
      2'b01: begin
        be_c    = 4'(4'b0011 << memAddress[1:0]);
        wdata_c = {2{dataOut_m[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = dataOut_m;
      end
    endcase
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  ld_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  ld_data_c = {24'd0, shifted_c[7:0]};
      3'b101:  ld_data_c = {16'd0, shifted_c[15:0]};
      default: ld_data_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr;
    wb_data_d   = wb_data;
    err_d       = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (is_load || is_store) begin
            if (!f3_ok || misaligned) begin
              err_d = 1'b1;
            end else begin
              stall_c     = 1'b1;
              state_d     = S_BUSY;
              cnt_d       = '0;
              f3_d        = funct3;
              off_d       = memAddress[1:0];
              rd_d        = rdAddress;
              mem_req_d   = 1'b1;
              mem_we_d    = is_store;
              mem_addr_d  = {memAddress[31:2], 2'b00};
              mem_be_d    = be_c;
              mem_wdata_d = wdata_c;
            end
          end else begin
            wb_en_d   = (rdAddress != 5'd0);
            wb_addr_d = rdAddress;
            wb_data_d = dataOut_r;
          end
        end
      end
      default: begin
        // Ack takes priority over a timeout landing in the same cycle
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (!mem_we) begin
            wb_en_d   = (rd_q != 5'd0);
            wb_addr_d = rd_q;
            wb_data_d = ld_data_c;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      wb_en     <= wb_en_d;
      wb_addr   <= wb_addr_d;
      wb_data   <= wb_data_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the fewcore pipeline, directly downstream of the write stage.
- Consumes the write stage's registered outputs: ALU result/address, store data, destination register and instruction code.
- Performs byte/half/word loads and stores over a req/ack data-memory port and stalls upstream while a transaction is outstanding.
- Produces the register-file writeback (wb_en/wb_addr/wb_data) and a misalignment/bus-timeout error pulse.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ack before aborting with err

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  upstream instruction present
code  input  12  [6:0]=opcode, [9:7]=funct3, [11:10] reserved (ignored)
rdAddress  input  5  destination register
dataOut_r  input  32  ALU result (writeback data for non-memory ops)
dataOut_m  input  32  store data (rs2)
memAddress  input  32  byte address for loads/stores
stall  output  1  upstream must hold its outputs (combinational)
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = store
mem_addr  output  32  word-aligned address ({memAddress[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  32  lane-shifted store data
mem_ack  input  1  memory completion (one-cycle pulse)
mem_rdata  input  32  read word, valid with mem_ack
wb_en  output  1  register write strobe, one cycle
wb_addr  output  5  register index
wb_data  output  32  register data
err  output  1  one-cycle error pulse (misaligned or timeout)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-transaction drops mem_req immediately; no writeback, no err.
- Decode:
  - LOAD = opcode 7'b0000011; STORE = 7'b0100011; anything else = ALU op.
  - funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - funct3 stores: 000 SB, 001 SH, 010 SW.
  - Other funct3 with a LOAD/STORE opcode is treated as misaligned (err).
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0. Result: no memory access, no writeback, err=1 for one cycle; the instruction is consumed with no stall.
- rd==0 never produces wb_en=1; the data path still runs.
- States: IDLE, BUSY.
- IDLE:
  - valid_in & ALU op: next edge wb_en=1, wb_addr=rdAddress, wb_data=dataOut_r. Latency 1, no stall.
  - valid_in & aligned mem op: stall=1 this cycle. Next edge: mem_req=1, mem_we, mem_addr, mem_be and mem_wdata registered from inputs; go to BUSY; counter cleared.
  - valid_in=0: wb_en=0.
- BUSY:
  - Outputs on the memory port are held stable.
  - stall = !mem_ack. Upstream advances on the ack cycle and must not re-present the completed instruction.
  - mem_ack=1: next edge mem_req=0 and state IDLE. Loads also assert wb_en with the extracted data.
  - No ack: counter increments. When the counter reaches TIMEOUT-1 without ack: abort, mem_req=0, err=1 one cycle, IDLE, stall released that cycle.
- Byte enables / store data:
  - SB: be=0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=0011<<addr[1:0], wdata={2{half}}.
  - SW: be=1111.
- Load extract: select the lane by addr[1:0]. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Edge cases:
  - mem_ack seen in IDLE is ignored.
  - Ack and timeout in the same cycle: ack wins, no err.
  - wb_en and err are never both 1.

Test Plan:
- ALU op, rdAddress=5, dataOut_r=0xDEADBEEF, valid_in=1 -> next cycle wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, stall never 1.
- SB, addr=0x1003, rs2=0x000000A5, ack after 3 cycles -> mem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, mem_we=1; stall high until the ack cycle; no wb_en.
- LB, addr=0x2002, mem_rdata=0x12F03456 -> wb_data=0xFFFFFFF0. Same with LBU -> 0x000000F0. LH at 0x2002 -> 0x000012F0.
- LW at addr=0x3001 -> err pulse, mem_req never asserted, no wb_en, stall=0.
- LW at 0x4000 with mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles then drops, err=1 one cycle, back to IDLE.
- LW with rd=0 -> mem transaction completes, wb_en stays 0. Reset pulled low during BUSY -> mem_req=0 immediately; after release, an ALU op proceeds normally.
